// File: rtl/aluctrl_pkg.sv
// rtl/aluctrl_pkg.sv - ALU control codes, ALUop/funct constants and FSM types for aluctrl_seq
package aluctrl_pkg;

    localparam logic [5:0] ALU_AND   = 6'h00;
    localparam logic [5:0] ALU_OR    = 6'h01;
    localparam logic [5:0] ALU_ADD   = 6'h02;
    localparam logic [5:0] ALU_ADDU  = 6'h03;
    localparam logic [5:0] ALU_XOR   = 6'h04;
    localparam logic [5:0] ALU_SUB   = 6'h06;
    localparam logic [5:0] ALU_SLT   = 6'h07;
    localparam logic [5:0] ALU_SLTU  = 6'h08;
    localparam logic [5:0] ALU_LUI   = 6'h09;
    // Each shift family is laid out as 1-op, 2-op, 8-op on consecutive codes.
    localparam logic [5:0] ALU_SLL1  = 6'h0A;
    localparam logic [5:0] ALU_SRL1  = 6'h0D;
    localparam logic [5:0] ALU_SRA1  = 6'h10;
    localparam logic [5:0] ALU_MULTU = 6'h13;
    localparam logic [5:0] ALU_CLIP  = 6'h30;
    localparam logic [5:0] ALU_DIV   = 6'h34;

    localparam logic [4:0] AOP_MEM   = 5'd0;
    localparam logic [4:0] AOP_BEQ   = 5'd1;
    localparam logic [4:0] AOP_RTYPE = 5'd2;
    localparam logic [4:0] AOP_ADDIU = 5'd3;
    localparam logic [4:0] AOP_ANDI  = 5'd4;
    localparam logic [4:0] AOP_ORI   = 5'd5;
    localparam logic [4:0] AOP_XORI  = 5'd6;
    localparam logic [4:0] AOP_SLTI  = 5'd7;
    localparam logic [4:0] AOP_SLTIU = 5'd8;
    localparam logic [4:0] AOP_LUI   = 5'd9;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_DIV   = 6'h30;
    localparam logic [5:0] F_CLIP  = 6'h34;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_e;
    typedef enum logic [1:0] {CLS_SINGLE, CLS_SHIFT, CLS_MULDIV} op_class_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/aluctrl_dec.sv
// rtl/aluctrl_dec.sv - combinational decode of ALUop/funct/Shamt into first code, class and step counts
// The divide decode exists only when ALUCTRL_SEQ_DIV_EN is defined.
module aluctrl_dec
    import aluctrl_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int MUL_CYCLES = 4
`ifdef ALUCTRL_SEQ_DIV_EN
    ,
    parameter int DIV_CYCLES = 33
`endif
) (
    input  logic [4:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [4:0]       shamt_i,
    output logic [5:0]       code_o,
    output op_class_e        class_o,
    output logic [5:0]       sh_base_o,
    output logic [1:0]       sh_a_o,
    output logic [1:0]       sh_b_o,
    output logic             sh_c_o,
    output logic [CNT_W-1:0] wait_rem_o
);

    // Cycles remaining after the issue cycle.
    localparam logic [CNT_W-1:0] MUL_REM = CNT_W'(MUL_CYCLES - 1);
`ifdef ALUCTRL_SEQ_DIV_EN
    localparam logic [CNT_W-1:0] DIV_REM = CNT_W'(DIV_CYCLES - 1);
`endif

    logic [5:0] base;

    always_comb begin
        code_o     = ALU_AND;
        class_o    = CLS_SINGLE;
        base       = ALU_SLL1;
        wait_rem_o = '0;
        sh_a_o     = shamt_i[4:3];
        sh_b_o     = shamt_i[2:1];
        sh_c_o     = shamt_i[0];
        case (alu_op_i)
            AOP_MEM:   code_o = ALU_ADD;
            AOP_BEQ:   code_o = ALU_SUB;
            AOP_ADDIU: code_o = ALU_ADDU;
            AOP_ANDI:  code_o = ALU_AND;
            AOP_ORI:   code_o = ALU_OR;
            AOP_XORI:  code_o = ALU_XOR;
            AOP_SLTI:  code_o = ALU_SLT;
            AOP_SLTIU: code_o = ALU_SLTU;
            AOP_LUI:   code_o = ALU_LUI;
            AOP_RTYPE: begin
                case (funct_i)
                    F_ADD:  code_o = ALU_ADD;
                    F_ADDU: code_o = ALU_ADDU;
                    F_SUBU: code_o = ALU_SUB;
                    F_AND:  code_o = ALU_AND;
                    F_OR:   code_o = ALU_OR;
                    F_XOR:  code_o = ALU_XOR;
                    F_SLT:  code_o = ALU_SLT;
                    F_SLTU: code_o = ALU_SLTU;
                    F_CLIP: code_o = ALU_CLIP;
                    F_MFHI, F_MFLO: code_o = ALU_AND;
                    F_SLL, F_SRL, F_SRA: begin
                        base = (funct_i == F_SLL) ? ALU_SLL1 :
                               (funct_i == F_SRL) ? ALU_SRL1 : ALU_SRA1;
                        // Shamt 0 stays a plain single-cycle 0x00.
                        if (shamt_i != 5'd0) begin
                            class_o = CLS_SHIFT;
                            if (shamt_i[4:3] != 2'd0)
                                code_o = base + 6'd2;
                            else if (shamt_i[2:1] != 2'd0)
                                code_o = base + 6'd1;
                            else
                                code_o = base;
                        end
                    end
                    F_MULTU: begin
                        code_o     = ALU_MULTU;
                        class_o    = CLS_MULDIV;
                        wait_rem_o = MUL_REM;
                    end
`ifdef ALUCTRL_SEQ_DIV_EN
                    F_DIV: begin
                        code_o     = ALU_DIV;
                        class_o    = CLS_MULDIV;
                        wait_rem_o = DIV_REM;
                    end
`endif
                    default: code_o = ALU_AND;
                endcase
            end
            default: code_o = ALU_AND;
        endcase
        sh_base_o = base;
    end

endmodule

// File: rtl/aluctrl_seq.sv
// rtl/aluctrl_seq.sv - sequenced ALU controller: shift stepping, mul/div hold and valid/ready stall
// Divide support is built only when ALUCTRL_SEQ_DIV_EN is defined.
module aluctrl_seq
    import aluctrl_pkg::*;
#(
    parameter int CTRL_W     = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [4:0]        ALUop,
    input  logic [5:0]        functionCode,
    input  logic [4:0]        Shamt,
    output logic              ready_o,
    output logic [CTRL_W-1:0] ALUctrl,
    output logic              step_valid_o,
    output logic              feedback_o,
    output logic              last_o,
    output logic              stall_o
);

    localparam int CNT_W = $clog2(max3(MUL_CYCLES, DIV_CYCLES, 8));

    state_e            state_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              step_valid_q, feedback_q, last_q;
    logic [5:0]        sh_base_q;
    logic [1:0]        cnt8_q, cnt2_q;
    logic              cnt1_q;
    logic [CNT_W-1:0]  wait_q;

    logic [5:0]        dec_code, dec_base;
    op_class_e         dec_class;
    logic [1:0]        dec_a, dec_b;
    logic              dec_c;
    logic [CNT_W-1:0]  dec_wait;

    aluctrl_dec #(
        .CNT_W      (CNT_W),
        .MUL_CYCLES (MUL_CYCLES)
`ifdef ALUCTRL_SEQ_DIV_EN
        ,
        .DIV_CYCLES (DIV_CYCLES)
`endif
    ) u_dec (
        .alu_op_i   (ALUop),
        .funct_i    (functionCode),
        .shamt_i    (Shamt),
        .code_o     (dec_code),
        .class_o    (dec_class),
        .sh_base_o  (dec_base),
        .sh_a_o     (dec_a),
        .sh_b_o     (dec_b),
        .sh_c_o     (dec_c),
        .wait_rem_o (dec_wait)
    );

    logic accept;
    assign ready_o = (state_q == ST_IDLE) || last_q;
    assign stall_o = ~ready_o;
    assign accept  = valid_i && ready_o;

    // Step counts left after the first step of a newly accepted shift.
    logic [1:0] acc_cnt8_d, acc_cnt2_d;
    logic       acc_cnt1_d, acc_more;
    always_comb begin
        acc_cnt8_d = dec_a;
        acc_cnt2_d = dec_b;
        acc_cnt1_d = dec_c;
        if (dec_a != 2'd0)
            acc_cnt8_d = dec_a - 2'd1;
        else if (dec_b != 2'd0)
            acc_cnt2_d = dec_b - 2'd1;
        else
            acc_cnt1_d = 1'b0;
        acc_more = (acc_cnt8_d != 2'd0) || (acc_cnt2_d != 2'd0) || acc_cnt1_d;
    end

    // Next shift step while in SHIFT: largest remaining granule first.
    logic [5:0] sh_code_d;
    logic [1:0] cnt8_d, cnt2_d;
    logic       cnt1_d, sh_last;
    always_comb begin
        sh_code_d = sh_base_q;
        cnt8_d    = cnt8_q;
        cnt2_d    = cnt2_q;
        cnt1_d    = cnt1_q;
        if (cnt8_q != 2'd0) begin
            sh_code_d = sh_base_q + 6'd2;
            cnt8_d    = cnt8_q - 2'd1;
        end else if (cnt2_q != 2'd0) begin
            sh_code_d = sh_base_q + 6'd1;
            cnt2_d    = cnt2_q - 2'd1;
        end else begin
            cnt1_d = 1'b0;
        end
        sh_last = (cnt8_d == 2'd0) && (cnt2_d == 2'd0) && !cnt1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ctrl_q       <= '0;
            step_valid_q <= 1'b0;
            feedback_q   <= 1'b0;
            last_q       <= 1'b0;
            sh_base_q    <= '0;
            cnt8_q       <= '0;
            cnt2_q       <= '0;
            cnt1_q       <= 1'b0;
            wait_q       <= '0;
        end else if (accept) begin
            ctrl_q       <= CTRL_W'(dec_code);
            step_valid_q <= 1'b1;
            feedback_q   <= 1'b0;
            sh_base_q    <= dec_base;
            cnt8_q       <= acc_cnt8_d;
            cnt2_q       <= acc_cnt2_d;
            cnt1_q       <= acc_cnt1_d;
            wait_q       <= dec_wait;
            if (dec_class == CLS_SHIFT && acc_more) begin
                state_q <= ST_SHIFT;
                last_q  <= 1'b0;
            end else if (dec_class == CLS_MULDIV && dec_wait != '0) begin
                state_q <= ST_WAIT;
                last_q  <= 1'b0;
            end else begin
                state_q <= ST_IDLE;
                last_q  <= 1'b1;
            end
        end else begin
            // The FSM returns to IDLE on the edge that presents the final cycle.
            case (state_q)
                ST_SHIFT: begin
                    ctrl_q       <= CTRL_W'(sh_code_d);
                    step_valid_q <= 1'b1;
                    feedback_q   <= 1'b1;
                    cnt8_q       <= cnt8_d;
                    cnt2_q       <= cnt2_d;
                    cnt1_q       <= cnt1_d;
                    last_q       <= sh_last;
                    if (sh_last)
                        state_q <= ST_IDLE;
                end
                ST_WAIT: begin
                    step_valid_q <= 1'b0;
                    feedback_q   <= 1'b0;
                    wait_q       <= wait_q - CNT_W'(1);
                    last_q       <= (wait_q == CNT_W'(1));
                    if (wait_q == CNT_W'(1))
                        state_q <= ST_IDLE;
                end
                default: begin
                    step_valid_q <= 1'b0;
                    feedback_q   <= 1'b0;
                    last_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ALUctrl      = ctrl_q;
    assign step_valid_o = step_valid_q;
    assign feedback_o   = feedback_q;
    assign last_o       = last_q;

endmodule

// File: tb/tb_aluctrl_seq.sv
// tb/tb_aluctrl_seq.sv - self-checking bench for aluctrl_seq with a queue-based reference model
module tb_aluctrl_seq;

    localparam int CTRL_W = 6;
    localparam int MUL_C  = 4;
    localparam int DIV_C  = 33;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_i = 1'b0;
    logic [4:0]        ALUop = '0;
    logic [5:0]        functionCode = '0;
    logic [4:0]        Shamt = '0;
    logic              ready_o, step_valid_o, feedback_o, last_o, stall_o;
    logic [CTRL_W-1:0] ALUctrl;

    aluctrl_seq #(.CTRL_W(CTRL_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ALUop(ALUop),
        .functionCode(functionCode), .Shamt(Shamt), .ready_o(ready_o),
        .ALUctrl(ALUctrl), .step_valid_o(step_valid_o), .feedback_o(feedback_o),
        .last_o(last_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One entry per output cycle of every accepted instruction.
    typedef struct {
        int code;
        bit sv;
        bit fb;
        bit last;
    } rec_t;
    rec_t exp_q[$];
    bit   acc_evt = 0, rst_edge = 0, after_rst = 0, run_chk = 0;

    function automatic void push_rec(input int code, input bit sv, input bit fb, input bit last);
        rec_t r;
        r.code = code; r.sv = sv; r.fb = fb; r.last = last;
        exp_q.push_back(r);
    endfunction

    function automatic int single_code(input int aop, input int f);
        case (aop)
            0: return 'h02;  1: return 'h06;  3: return 'h03;
            4: return 'h00;  5: return 'h01;  6: return 'h04;
            7: return 'h07;  8: return 'h08;  9: return 'h09;
            2: case (f)
                   'h20: return 'h02; 'h21: return 'h03; 'h23: return 'h06;
                   'h24: return 'h00; 'h25: return 'h01; 'h26: return 'h04;
                   'h2A: return 'h07; 'h2B: return 'h08; 'h34: return 'h30;
                   default: return 'h00;
               endcase
            default: return 'h00;
        endcase
    endfunction

    function automatic void push_instr(input int aop, input int f, input int sh);
        int base, k, n, cyc, code;
        bit is_div;
`ifdef ALUCTRL_SEQ_DIV_EN
        is_div = (aop == 2 && f == 'h30);
`else
        is_div = 1'b0;
`endif
        if (aop == 2 && (f == 0 || f == 2 || f == 3) && sh != 0) begin
            base = (f == 0) ? 'h0A : (f == 2) ? 'h0D : 'h10;
            k = sh / 8 + (sh % 8) / 2 + sh % 2;
            n = 0;
            for (int i = 0; i < sh / 8; i++) begin push_rec(base + 2, 1, n > 0, n == k - 1); n++; end
            for (int i = 0; i < (sh % 8) / 2; i++) begin push_rec(base + 1, 1, n > 0, n == k - 1); n++; end
            if (sh % 2 == 1) push_rec(base, 1, n > 0, 1);
        end else if ((aop == 2 && f == 'h19) || is_div) begin
            cyc  = is_div ? DIV_C : MUL_C;
            code = is_div ? 'h34 : 'h13;
            push_rec(code, 1, 0, cyc == 1);
            for (int i = 1; i < cyc; i++) push_rec(code, 0, 0, i == cyc - 1);
        end else begin
            push_rec(single_code(aop, f), 1, 0, 1);
        end
    endfunction

    // Reference model: advances one output cycle per edge.
    bit rdy_m;
    always @(posedge clk) begin
        rdy_m     = (exp_q.size() == 0) || exp_q[0].last;
        acc_evt   = 0;
        rst_edge  = rst;
        after_rst = rst;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (valid_i && rdy_m) begin
                push_instr(int'(ALUop), int'(functionCode), int'(Shamt));
                acc_evt = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            if (exp_q.size() > 0) begin
                check("m_ctrl", int'(ALUctrl), exp_q[0].code);
                check("m_sv", int'(step_valid_o), int'(exp_q[0].sv));
                check("m_last", int'(last_o), int'(exp_q[0].last));
                check("m_ready", int'(ready_o), int'(exp_q[0].last));
                if (exp_q[0].sv) check("m_fb", int'(feedback_o), int'(exp_q[0].fb));
            end else begin
                check("m_idle_sv", int'(step_valid_o), 0);
                check("m_idle_last", int'(last_o), 0);
                check("m_idle_ready", int'(ready_o), 1);
                if (after_rst) begin
                    check("m_rst_ctrl", int'(ALUctrl), 0);
                    check("m_rst_fb", int'(feedback_o), 0);
                end
            end
            check("m_stall", int'(stall_o), int'(!ready_o));
        end
    end

    task automatic drive(input bit v, input int a, input int f, input int s);
        valid_i = v; ALUop = 5'(a); functionCode = 6'(f); Shamt = 5'(s);
    endtask

    task automatic pick_new();
        int fl[16] = '{'h00, 'h02, 'h03, 'h10, 'h12, 'h19, 'h20, 'h21,
                       'h23, 'h24, 'h25, 'h26, 'h2A, 'h2B, 'h30, 'h34};
        int a, f;
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10);
        if ($urandom_range(0, 1) == 0) a = 2;
        f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : fl[$urandom_range(0, 15)];
        drive($urandom_range(0, 3) != 0, a, f, $urandom_range(0, 31));
    endtask

    int c13[4]  = '{'h0C, 'h0B, 'h0B, 'h0A};
    int f13[4]  = '{0, 1, 1, 1};
    int c31[8]  = '{'h12, 'h12, 'h12, 'h11, 'h11, 'h11, 'h10, 'h03};
    int last_cnt;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_chk = 1;
        check("rst_ctrl", int'(ALUctrl), 0);
        check("rst_sv", int'(step_valid_o), 0);
        check("rst_last", int'(last_o), 0);
        check("rst_ready", int'(ready_o), 1);
        check("rst_stall", int'(stall_o), 0);

        drive(1, 2, 'h20, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        check("add_ctrl", int'(ALUctrl), 'h02);
        check("add_sv", int'(step_valid_o), 1);
        check("add_last", int'(last_o), 1);
        check("add_ready", int'(ready_o), 1);

        @(negedge clk); drive(1, 2, 'h00, 13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(0, 0, 0, 0);
            check("sll13_ctrl", int'(ALUctrl), c13[i]);
            check("sll13_fb", int'(feedback_o), f13[i]);
            check("sll13_last", int'(last_o), (i == 3) ? 1 : 0);
            check("sll13_stall", int'(stall_o), (i < 3) ? 1 : 0);
        end

        @(negedge clk); drive(1, 2, 'h03, 31);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) drive(1, 3, 0, 0);
            if (i == 7) drive(0, 0, 0, 0);
            check("sra31_ctrl", int'(ALUctrl), c31[i]);
            check("sra31_sv", int'(step_valid_o), 1);
        end

        @(negedge clk); drive(1, 2, 'h19, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(0, 0, 0, 0);
            check("mul_ctrl", int'(ALUctrl), 'h13);
            check("mul_sv", int'(step_valid_o), (i == 0) ? 1 : 0);
            check("mul_last", int'(last_o), (i == 3) ? 1 : 0);
        end

        @(negedge clk); drive(1, 2, 'h30, 0);
`ifdef ALUCTRL_SEQ_DIV_EN
        last_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk); drive(0, 0, 0, 0);
            if (i < 32) last_cnt += int'(last_o);
            if (i == 0) check("div_sv", int'(step_valid_o), 1);
        end
        check("div_ctrl", int'(ALUctrl), 'h34);
        check("div_early_last", last_cnt, 0);
        check("div_last", int'(last_o), 1);
`else
        @(negedge clk); drive(0, 0, 0, 0);
        check("div_off_ctrl", int'(ALUctrl), 'h00);
        check("div_off_last", int'(last_o), 1);
`endif

        @(negedge clk); drive(1, 2, 'h03, 31);
        @(negedge clk); drive(0, 0, 0, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mrst_ctrl", int'(ALUctrl), 0);
        check("mrst_sv", int'(step_valid_o), 0);
        check("mrst_fb", int'(feedback_o), 0);
        check("mrst_ready", int'(ready_o), 1);
        drive(1, 2, 'h21, 0);
        @(negedge clk); drive(0, 0, 0, 0);
        check("mrst_next_ctrl", int'(ALUctrl), 'h03);
        check("mrst_next_last", int'(last_o), 1);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            if (!(valid_i && !acc_evt && !rst_edge)) pick_new();
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        repeat (40) @(negedge clk);
        run_chk = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aluctrl_seq.md
# aluctrl_seq

Sequenced ALU controller for the mMIPS execute stage: the multi-cycle successor of the combinational ALU control decoder. It decodes ALUop/functionCode/Shamt into ALU control codes. Shifts by any amount 0–31 are built from the ALU's fixed 8/2/1-bit shift operations. Multiply and divide are held for a configurable number of cycles, and the pipeline is stalled through a valid/ready handshake.

## Interface
Parameters:
- CTRL_W, 6: ALU control code width; must be at least 6.
- MUL_CYCLES, 4: total cycles for a multiply, including the issue cycle; must be at least 1.
- DIV_CYCLES, 33: total cycles for a divide, including the issue cycle; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  a decoded instruction is present in EX.
- ALUop  in  5  ALU operation class from the main controller.
- functionCode  in  6  R-type funct field.
- Shamt  in  5  R-type shift amount.
- ready_o  out  1  the instruction is accepted at the next edge if valid_i is high.
- ALUctrl  out  CTRL_W  ALU control code; registered.
- step_valid_o  out  1  the ALU must execute ALUctrl this cycle.
- feedback_o  out  1  ALU operand A is the previous ALU result, not the register file.
- last_o  out  1  final cycle of the current instruction.
- stall_o  out  1  equals ~ready_o; freezes IF/ID/EX.

## Operation
- States: IDLE, SHIFT, WAIT.
- Single-cycle decode is the legacy table:
  - ALUop 0→0x02, 1→0x06, 3→0x03, 4→0x00, 5→0x01, 6→0x04, 7→0x07, 8→0x08, 9→0x09; other ALUop values →0x00.
  - ALUop 2 uses funct: 0x20→0x02, 0x21→0x03, 0x23→0x06, 0x24→0x00, 0x25→0x01, 0x26→0x04, 0x2A→0x07, 0x2B→0x08, 0x34 (clip)→0x30, 0x10/0x12→0x00; other funct values →0x00.
- Shift (ALUop 2, funct 0x00/0x02/0x03 = SLL/SRL/SRA):
  - Shamt is split as 8a+2b+c, with a≤3, b≤3, c≤1.
  - Steps are issued largest first: a steps of the 8-op, then b steps of the 2-op, then c steps of the 1-op.
  - Codes: SLL 0x0C/0x0B/0x0A, SRL 0x0F/0x0E/0x0D, SRA 0x12/0x11/0x10.
  - Shamt 0 issues a single step with code 0x00.
  - feedback_o is 0 on the first step and 1 on every later step.
- Multiply (funct 0x19→0x13) and divide (funct 0x30→0x34):
  - The code is issued once with step_valid_o=1.
  - FSM then goes to WAIT for the remaining cycles; ALUctrl holds the code and step_valid_o=0.
  - If the cycle count is 1, the operation behaves as single-cycle.
- Transitions:
  - IDLE→SHIFT on accepting a shift with more than one step.
  - IDLE→WAIT on accepting a multiply/divide with cycle count > 1.
  - SHIFT/WAIT→IDLE after the cycle with last_o=1, unless a new instruction is accepted in that cycle. In that case the FSM goes directly to the new instruction's state.
- ready_o = (state==IDLE and no step in flight) OR last_o.
- valid_i is ignored while ready_o=0. The inputs must be held stable by upstream until accepted.
- Reset values:
  - ALUctrl=0, step_valid_o=0, feedback_o=0, last_o=0.
  - state=IDLE, so ready_o=1 and stall_o=0.
  - valid_i is ignored while rst is high.
- Reset in mid-sequence aborts the sequence. Outputs take their reset values at the next edge, and no further steps are issued.

## Timing
- An instruction accepted at edge N shows its first step at N+1. Latency to the first step is 1 cycle.
- Single-cycle op: one step, at N+1, with last_o=1.
- Shift of k steps: steps at N+1..N+k; last_o at N+k.
  - k = a+b+c; maximum k is 7, for Shamt 31.
- Multiply: last_o at N+MUL_CYCLES.
- Divide: last_o at N+DIV_CYCLES.
- Back-to-back: ready_o is high in the last_o cycle, so the next instruction's first step appears the following cycle with no bubble.
- Step counter width: $clog2(max(MUL_CYCLES, DIV_CYCLES, 8)).

## Configuration
- Macro ALUCTRL_SEQ_DIV_EN.
- Defined: funct 0x30 issues 0x34 and waits DIV_CYCLES in total.
- Undefined:
  - funct 0x30 decodes as default: single-cycle, code 0x00.
  - The DIV_CYCLES parameter is accepted but unused.
  - The divide counter logic is not built.

## Structure
- Shared package aluctrl_pkg holds:
  - ALU code constants (AND, OR, ADD, ADDU, XOR, SUB, SLT, SLTU, LUI, the shift codes, MULTU, DIV, CLIP).
  - ALUop constants and funct constants.
  - The state enum.
- Sub-module aluctrl_dec: purely combinational decode of (ALUop, functionCode, Shamt) to:
  - first code,
  - op class (single/shift/muldiv),
  - shift counts a/b/c,
  - wait cycles.
- The top level contains only the FSM, counters and output registers.

## Test plan
- ALUop 2, funct 0x20, accept at N → ALUctrl=0x02, step_valid_o=1, last_o=1 at N+1; ready_o stays 1 throughout.
- SLL, Shamt 13 → codes 0x0C, 0x0B, 0x0B, 0x0A at N+1..N+4; feedback_o=0,1,1,1; last_o only at N+4; stall_o high at N+1..N+3.
- SRA, Shamt 31 followed immediately by an ADDU (ALUop 3) → codes 0x12×3, 0x11×3, 0x10, then 0x03 at N+8 with no gap.
- MULTU with MUL_CYCLES=4 → ALUctrl=0x13 for N+1..N+4, step_valid_o only at N+1, last_o at N+4.
- DIV with the macro defined and DIV_CYCLES=33 → last_o at N+33; without the macro → code 0x00, single-cycle.
- rst asserted at N+2 of a Shamt-31 shift → at N+3 all outputs are 0 and ready_o=1; a new instruction is then accepted normally.
